// File: rtl/fifo_ctrl_pkg.sv
// Shared types and sizing helpers for the FIFO flow controller.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } ctrl_state_e;

    // Occupancy width: must represent 0..size inclusive.
    function automatic int unsigned cw_f(input int unsigned size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Word-occupancy counter; applies +UP and/or -DOWN in a single edge.
module occupancy_counter #(
    parameter int unsigned CW   = 5,
    parameter int unsigned UP   = 1,
    parameter int unsigned DOWN = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          up_en_i,
    input  logic          down_en_i,
    output logic [CW-1:0] level_o
);

    localparam logic [CW-1:0] UpW   = CW'(UP);
    localparam logic [CW-1:0] DownW = CW'(DOWN);

    logic [CW-1:0] level_q, level_d;

    // Callers never request a change that leaves 0..SIZE, so modular math is exact.
    always_comb begin
        level_d = level_q;
        if (up_en_i)   level_d = level_d + UpW;
        if (down_en_i) level_d = level_d - DownW;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) level_q <= '0;
        else         level_q <= level_d;
    end

    assign level_o = level_q;

endmodule

// File: rtl/fifo_flow_controller.sv
// Handshake-to-enable sequencer for the circular-buffer FIFO datapath,
// with IDLE/RUN/DRAIN control and sticky datapath-flag mismatch detection.
module fifo_flow_controller
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned SIZE      = 16,
    parameter int unsigned PAR_WRITE = 1,
    parameter int unsigned PAR_READ  = 1,
    parameter int unsigned AF_LEVEL  = 12,
    localparam int unsigned CW       = cw_f(SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          drain_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          write_enable_o,
    output logic          read_enable_o,
    input  logic          dp_full_i,
    input  logic          dp_empty_i,
    output logic [CW-1:0] level_o,
    output logic          almost_full_o,
    output logic          drain_done_o,
    output logic          err_o
);

    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW:0]   SizeW    = CW1'(SIZE);
    localparam logic [CW:0]   ParWrW   = CW1'(PAR_WRITE);
    localparam logic [CW-1:0] ParRdW   = CW'(PAR_READ);
    localparam logic [CW-1:0] AfLevelW = CW'(AF_LEVEL);

    ctrl_state_e   state_q;
    logic          drain_done_q;
    logic          err_q;
    logic [CW-1:0] level;
    logic          in_ready, out_valid, we, re;

    // Headroom check at CW+1 bits so level+PAR_WRITE cannot wrap.
    assign in_ready  = (state_q == StRun) && (({1'b0, level} + ParWrW) <= SizeW);
    assign out_valid = (state_q != StIdle) && (level >= ParRdW);
    assign we        = in_valid_i && in_ready;
    assign re        = out_valid && out_ready_i;

    occupancy_counter #(
        .CW   (CW),
        .UP   (PAR_WRITE),
        .DOWN (PAR_READ)
    ) u_occupancy_counter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .up_en_i   (we),
        .down_en_i (re),
        .level_o   (level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            drain_done_q <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            unique case (state_q)
                StIdle:  if (start_i) state_q <= StRun;
                StRun:   if (drain_i) state_q <= StDrain;
                StDrain: begin
                    // Residue below PAR_READ is left in the buffer.
                    if (level < ParRdW) begin
                        state_q      <= StIdle;
                        drain_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if ((dp_full_i && in_ready) || (dp_empty_i && out_valid)) begin
            err_q <= 1'b1;
        end
    end

    assign in_ready_o     = in_ready;
    assign out_valid_o    = out_valid;
    assign write_enable_o = we;
    assign read_enable_o  = re;
    assign level_o        = level;
    assign almost_full_o  = (level >= AfLevelW);
    assign drain_done_o   = drain_done_q;
    assign err_o          = err_q;

endmodule
